// File: rtl/subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module : subtractor_pkg
// Brief  : Shared state encoding and default width for the serial subtractor.
// Rev    : 1.0
// ============================================================================
package subtractor_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module : serial_subtractor_if
// Brief  : start/busy/done handshake plus operand and result bus.
// Rev    : 1.0
// ============================================================================
interface serial_subtractor_if
  import subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module : full_subtractor
// Brief  : One-bit combinational full subtractor cell (a - b - bin).
// Rev    : 1.0
// ============================================================================
module full_subtractor (
  input  wire logic a,
  input  wire logic b,
  input  wire logic bin,
  output logic      diff,
  output logic      bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module : serial_subtractor
// Brief  : Bit-serial a - b, LSB first, one bit per clock via a single cell.
// Rev    : 1.0
// ============================================================================
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  serial_subtractor_if.slave bus
);

  localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int                 MSB      = WIDTH - 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   d_sh_q, d_sh_d;
  logic               bw_q, bw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;
  logic               overflow_q, overflow_d;

  logic               fs_diff;
  logic               fs_bout;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bw_q),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    d_sh_d       = d_sh_q;
    bw_d         = bw_q;
    cnt_d        = cnt_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          bw_d    = 1'b0;
          cnt_d   = '0;
          sa_d    = bus.a[MSB];
          sb_d    = bus.b[MSB];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        d_sh_d = {fs_diff, d_sh_q[MSB:1]};
        bw_d   = fs_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        // The last cell output is the result MSB, so publish directly from it.
        if (cnt_q == CNT_LAST) begin
          diff_d       = {fs_diff, d_sh_q[MSB:1]};
          borrow_out_d = fs_bout;
          overflow_d   = (sa_q ^ sb_q) & (fs_diff ^ sa_q);
          state_d      = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      d_sh_q       <= '0;
      bw_q         <= 1'b0;
      cnt_q        <= '0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      d_sh_q       <= d_sh_d;
      bw_q         <= bw_d;
      cnt_q        <= cnt_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.busy       = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing `a - b` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart to the adder library's full-adder cells. It serves area-constrained datapaths that can tolerate WIDTH-cycle latency. A start/busy/done handshake lets a controller issue operations back-to-back.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits (≥2).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a subtraction; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured when start is accepted.
- `b`  in  WIDTH  subtrahend; captured when start is accepted.
- `busy`  out  1  high while an operation is in progress (RUN or DONE).
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `diff`  out  WIDTH  `a - b` mod 2^WIDTH.
- `borrow_out`  out  1  final borrow: 1 iff unsigned `a < b`.
- `overflow`  out  1  signed overflow: `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.

## Operation
- Internal state:
  - FSM: IDLE, RUN, DONE.
  - Shift registers `a_sh`, `b_sh`, `d_sh`.
  - Borrow flop `bw`.
  - Bit counter `cnt` of width `$clog2(WIDTH)`.
  - Captured sign bits `sa`, `sb`.
- IDLE:
  - With `start=1`: load `a_sh<=a` and `b_sh<=b`; set `bw<=0` and `cnt<=0`; latch `sa<=a[MSB]` and `sb<=b[MSB]`; go to RUN.
  - Otherwise stay in IDLE and hold all outputs.
- RUN, each cycle:
  - Form `d,bo` from `full_subtractor(a_sh[0], b_sh[0], bw)`.
  - Shift `d` into `d_sh` from the top.
  - Shift `a_sh` and `b_sh` right by one.
  - Set `bw<=bo` and `cnt<=cnt+1`.
  - When `cnt==WIDTH-1`, go to DONE, updating `diff`, `borrow_out` and `overflow` on that same edge from the final bit.
- DONE: `done=1` for exactly this one cycle, then go unconditionally to IDLE.
- `start` is ignored in RUN and DONE: no queuing, and operands already loaded are not disturbed.
- `diff`, `borrow_out` and `overflow` are registered. They change only on the RUN→DONE edge and hold until the next completion. `start` alone does not clear them.
- Cell equations:
  - `d = a ^ b ^ bin`
  - `bout = (~a & b) | (~(a ^ b) & bin)`
- Reset, asynchronous, any state:
  - State returns to IDLE.
  - `busy=0`, `done=0`, `diff=0`, `borrow_out=0`, `overflow=0`.
  - Shift registers, `bw` and `cnt` are cleared.
  - An operation in flight is discarded; no `done` pulse follows.
- Edge operands:
  - `a==b` gives `diff=0`, `borrow_out=0`.
  - `b==0` gives `diff=a`.
  - `a=0`, `b=1` gives all-ones with `borrow_out=1`.

## Timing
- Start accepted at rising edge k (IDLE, `start=1`): `busy=1` after edge k.
- RUN occupies edges k+1 … k+WIDTH.
- Result registers update and `done` rises after edge k+WIDTH; `done` stays high for one cycle.
- IDLE after edge k+WIDTH+1; `busy=0` from then.
- Latency from start to `done` is WIDTH cycles. Issue interval is WIDTH+2 cycles: the earliest next `start` is accepted at edge k+WIDTH+2, with `start` held or reasserted in the IDLE cycle.
- `busy` is a pure decode of state: IDLE→0, RUN/DONE→1. `done` is a decode of DONE.
- Reset deassertion is synchronized externally. The first accepted `start` is on the first edge after `rst_n` is high.

## Structure
- Package `subtractor_pkg` holds:
  - the state encoding localparams (`ST_IDLE=2'd0`, `ST_RUN=2'd1`, `ST_DONE=2'd2`);
  - the default WIDTH constant.
- Sub-module `full_subtractor` (ports `a, b, bin, diff, bout`): purely combinational, one instance. It is reusable by a future ripple-borrow subtractor.
- Top-level `serial_subtractor` holds the FSM, shift registers, counter and output registers.

## Test plan
- WIDTH=8, `a=8'h5A`, `b=8'h3C`, start pulse → `done` exactly 8 cycles after the accept edge; `diff=8'h1E`, `borrow_out=0`, `overflow=0`.
- `a=8'h00`, `b=8'h01` → `diff=8'hFF`, `borrow_out=1`, `overflow=0`. Then `a=8'h80`, `b=8'h01` → `diff=8'h7F`, `borrow_out=0`, `overflow=1`.
- `start` held high continuously with new operands (`8'h10-8'h10`, then `8'h03-8'h07`):
  - first result is `diff=0`;
  - second result is `diff=8'hFC`, `borrow_out=1`;
  - accepts are exactly 10 cycles apart;
  - `done` is never two cycles wide.
- `start` pulsed with different `a`/`b` during RUN → ignored; result matches the originally captured operands; `busy` is unbroken.
- `rst_n` asserted asynchronously (mid-cycle) at bit 4 of an operation → all outputs 0 immediately. No `done` follows. The next `start` computes correctly from a clean borrow.
- Random sweep of 1000 operand pairs, plus WIDTH=2 and WIDTH=16 builds → `diff`, `borrow_out` and `overflow` match the reference model `{borrow, diff} = {1'b0, a} - {1'b0, b}`.
